// File: rtl/addsub_arb_pkg.sv
// Shared types and constants for the add/sub arbiter slice.
// Optional feature macro used by the top: ADDSUB_ARB_FIXED_PRIO_EN.
package addsub_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_NUM_REQ = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_arbiter_if.sv
// Request/response bundle between the client engines and the shared add/sub arbiter.
interface addsub_arbiter_if
    import addsub_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int ID_W    = 2
);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]       req_sub;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [WIDTH-1:0]         rsp_s;
    logic                     rsp_cout;

    // Client side drives requests and consumes responses.
    modport master (
        output req_valid, req_a, req_b, req_sub, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_s, rsp_cout
    );

    modport slave (
        input  req_valid, req_a, req_b, req_sub, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_s, rsp_cout
    );

endinterface

// File: rtl/addsub_core.sv
// Combinational WIDTH-bit ripple adder/subtractor; cout is carry on add, borrow on sub.
module addsub_core
    import addsub_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    logic [WIDTH-1:0] bx;
    logic [WIDTH:0]   c;

    always_comb begin
        s    = '0;
        c    = '0;
        bx   = b ^ {WIDTH{sub}};
        // Subtraction is a + ~b + 1, so the carry chain is seeded with the op bit.
        c[0] = (sub == OP_SUB);
        for (int i = 0; i < WIDTH; i++) begin
            s[i]   = a[i] ^ bx[i] ^ c[i];
            c[i+1] = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
        end
        cout = c[WIDTH] ^ sub;
    end

endmodule

// File: rtl/addsub_arbiter.sv
// Shares one add/sub datapath among NUM_REQ requesters via an IDLE/EXEC/RESP FSM.
// Define ADDSUB_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module addsub_arbiter
    import addsub_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int ID_W    = 2
) (
    input  logic             clk,
    input  logic             rst,
    addsub_arbiter_if.slave  bus
);

    state_t             state;
    logic               any_req;
    logic [ID_W-1:0]    grant;
    logic [NUM_REQ-1:0] req_ready_c;

    logic [WIDTH-1:0]   a_sel;
    logic [WIDTH-1:0]   b_sel;
    logic               sub_sel;

    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic               op_sub;
    logic [ID_W-1:0]    op_id;

    logic [WIDTH-1:0]   core_s;
    logic               core_cout;

    logic               rsp_valid_r;
    logic [ID_W-1:0]    rsp_id_r;
    logic [WIDTH-1:0]   rsp_s_r;
    logic               rsp_cout_r;

    assign any_req = |bus.req_valid;

`ifdef ADDSUB_ARB_FIXED_PRIO_EN
    // Descending scan so the lowest valid index is the last (winning) assignment.
    always_comb begin
        grant = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) grant = ID_W'(i);
        end
    end
`else
    localparam logic [ID_W:0] NREQ_E = (ID_W + 1)'(NUM_REQ);

    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] ptr_next;
    logic [ID_W:0]   rr_idx;

    // Scan offsets from ptr downwards so the smallest offset wins the grant.
    always_comb begin
        grant  = '0;
        rr_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            rr_idx = {1'b0, ptr} + (ID_W + 1)'(k);
            if (rr_idx >= NREQ_E) rr_idx = rr_idx - NREQ_E;
            if (bus.req_valid[rr_idx[ID_W-1:0]]) grant = rr_idx[ID_W-1:0];
        end
    end

    assign ptr_next = (op_id == ID_W'(NUM_REQ - 1)) ? '0 : op_id + 1'b1;
`endif

    always_comb begin
        a_sel   = '0;
        b_sel   = '0;
        sub_sel = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant == ID_W'(i)) begin
                a_sel   = bus.req_a[i*WIDTH +: WIDTH];
                b_sel   = bus.req_b[i*WIDTH +: WIDTH];
                sub_sel = bus.req_sub[i];
            end
        end
    end

    // Ready is gated by rst so an asserted reset masks acceptance immediately.
    always_comb begin
        req_ready_c = '0;
        if (state == IDLE && !rst && any_req) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant == ID_W'(i)) req_ready_c[i] = 1'b1;
            end
        end
    end

    addsub_core #(.WIDTH(WIDTH)) u_core (
        .a    (op_a),
        .b    (op_b),
        .sub  (op_sub),
        .s    (core_s),
        .cout (core_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            op_a        <= '0;
            op_b        <= '0;
            op_sub      <= 1'b0;
            op_id       <= '0;
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= '0;
            rsp_s_r     <= '0;
            rsp_cout_r  <= 1'b0;
`ifndef ADDSUB_ARB_FIXED_PRIO_EN
            ptr         <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        op_a   <= a_sel;
                        op_b   <= b_sel;
                        op_sub <= sub_sel;
                        op_id  <= grant;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_s_r     <= core_s;
                    rsp_cout_r  <= core_cout;
                    rsp_id_r    <= op_id;
                    rsp_valid_r <= 1'b1;
`ifndef ADDSUB_ARB_FIXED_PRIO_EN
                    ptr         <= ptr_next;
`endif
                    state       <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_id    = rsp_id_r;
    assign bus.rsp_s     = rsp_s_r;
    assign bus.rsp_cout  = rsp_cout_r;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed self-checking bench for addsub_arbiter (round-robin or fixed-priority build).
module tb_addsub_arbiter;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    addsub_arbiter_if #(.NUM_REQ(4), .WIDTH(8), .ID_W(2)) bus ();

    addsub_arbiter #(.NUM_REQ(4), .WIDTH(8), .ID_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic test_reset();
        rst           = 1'b1;
        bus.req_valid = 4'hF;
        bus.req_a     = 32'h44332211;
        bus.req_b     = 32'h01010101;
        bus.req_sub   = 4'h0;
        bus.rsp_ready = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if (bus.req_ready !== 4'b0000) $display("FAIL reset_ready got %b exp %b", bus.req_ready, 4'b0000);
        else n_pass++;
        n_checks++;
        if (bus.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b exp 0", bus.rsp_valid);
        else n_pass++;
        n_checks++;
        if ({bus.rsp_id, bus.rsp_s, bus.rsp_cout} !== 11'h000)
            $display("FAIL reset_rsp_regs got id=%h s=%h c=%b exp 0/00/0", bus.rsp_id, bus.rsp_s, bus.rsp_cout);
        else n_pass++;
        bus.req_valid = 4'h0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Single request from one requester; checks same-cycle ready, EXEC gap, response at T+2, drop after.
    task automatic test_op(input string name, input int idx, input logic [7:0] a, input logic [7:0] b,
                           input logic sub, input logic [7:0] exp_s, input logic exp_c);
        logic [3:0] exp_rdy;
        exp_rdy = 4'b0001 << idx;
        bus.rsp_ready              = 1'b1;
        bus.req_a[idx*8 +: 8]      = a;
        bus.req_b[idx*8 +: 8]      = b;
        bus.req_sub[idx]           = sub;
        bus.req_valid              = exp_rdy;
        #1;
        n_checks++;
        if (bus.req_ready !== exp_rdy) $display("FAIL %s_ready got %b exp %b", name, bus.req_ready, exp_rdy);
        else n_pass++;
        @(negedge clk);
        bus.req_valid = 4'h0;
        #1;
        n_checks++;
        if ({bus.rsp_valid, bus.req_ready} !== 5'b0)
            $display("FAIL %s_exec got valid=%b ready=%b exp 0/0000", name, bus.rsp_valid, bus.req_ready);
        else n_pass++;
        @(negedge clk); #1;
        n_checks++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_s, bus.rsp_cout} !== {1'b1, 2'(idx), exp_s, exp_c})
            $display("FAIL %s_rsp got v=%b id=%0d s=%h c=%b exp v=1 id=%0d s=%h c=%b", name,
                     bus.rsp_valid, bus.rsp_id, bus.rsp_s, bus.rsp_cout, idx, exp_s, exp_c);
        else n_pass++;
        @(negedge clk); #1;
        n_checks++;
        if (bus.rsp_valid !== 1'b0) $display("FAIL %s_drop got %b exp 0", name, bus.rsp_valid);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [7:0] s_tab [4];
        int         g_tab [5];
        logic [3:0] exp_rdy;
        s_tab = '{8'h11, 8'h1E, 8'h33, 8'h3C};
`ifdef ADDSUB_ARB_FIXED_PRIO_EN
        g_tab = '{0, 0, 0, 0, 0};
`else
        g_tab = '{0, 1, 2, 3, 0};
`endif
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst           = 1'b0;
        bus.req_a     = 32'h40302010;
        bus.req_b     = 32'h04030201;
        bus.req_sub   = 4'b1010;
        bus.rsp_ready = 1'b1;
        bus.req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            exp_rdy = 4'b0001 << g_tab[k];
            #1;
            n_checks++;
            if (bus.req_ready !== exp_rdy) $display("FAIL rr_grant%0d got %b exp %b", k, bus.req_ready, exp_rdy);
            else n_pass++;
            @(negedge clk);
            @(negedge clk); #1;
            n_checks++;
            if ({bus.rsp_valid, bus.rsp_id, bus.rsp_s, bus.rsp_cout} !== {1'b1, 2'(g_tab[k]), s_tab[g_tab[k]], 1'b0})
                $display("FAIL rr_rsp%0d got v=%b id=%0d s=%h c=%b exp v=1 id=%0d s=%h c=0", k,
                         bus.rsp_valid, bus.rsp_id, bus.rsp_s, bus.rsp_cout, g_tab[k], s_tab[g_tab[k]]);
            else n_pass++;
            @(negedge clk);
        end
        bus.req_valid = 4'h0;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        bus.rsp_ready  = 1'b0;
        bus.req_a[15:8] = 8'h33;
        bus.req_b[15:8] = 8'h11;
        bus.req_sub[1]  = 1'b1;
        bus.req_valid   = 4'b0010;
        #1;
        n_checks++;
        if (bus.req_ready !== 4'b0010) $display("FAIL bp_ready got %b exp 0010", bus.req_ready);
        else n_pass++;
        @(negedge clk);
        bus.req_valid = 4'h0;
        @(negedge clk);
        bus.req_a[31:24] = 8'h09;
        bus.req_b[31:24] = 8'h03;
        bus.req_sub[3]   = 1'b1;
        bus.req_valid    = 4'b1000;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_checks++;
            if ({bus.rsp_valid, bus.rsp_id, bus.rsp_s, bus.rsp_cout, bus.req_ready} !== {1'b1, 2'd1, 8'h22, 1'b0, 4'b0000})
                $display("FAIL bp_hold%0d got v=%b id=%0d s=%h c=%b rdy=%b exp v=1 id=1 s=22 c=0 rdy=0000", k,
                         bus.rsp_valid, bus.rsp_id, bus.rsp_s, bus.rsp_cout, bus.req_ready);
            else n_pass++;
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if ({bus.rsp_valid, bus.req_ready} !== 5'b0_1000)
            $display("FAIL bp_release got v=%b rdy=%b exp v=0 rdy=1000", bus.rsp_valid, bus.req_ready);
        else n_pass++;
        @(negedge clk);
        bus.req_valid = 4'h0;
        @(negedge clk); #1;
        n_checks++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_s, bus.rsp_cout} !== {1'b1, 2'd3, 8'h06, 1'b0})
            $display("FAIL bp_next_rsp got v=%b id=%0d s=%h c=%b exp v=1 id=3 s=06 c=0",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_s, bus.rsp_cout);
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        bus.rsp_ready  = 1'b1;
        bus.req_a[7:0] = 8'h55;
        bus.req_b[7:0] = 8'h11;
        bus.req_sub[0] = 1'b0;
        bus.req_valid  = 4'b0001;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.rsp_valid, bus.req_ready} !== 5'b0)
            $display("FAIL rstmid_now got v=%b rdy=%b exp 0/0000", bus.rsp_valid, bus.req_ready);
        else n_pass++;
        @(negedge clk); #1;
        n_checks++;
        if (bus.rsp_valid !== 1'b0) $display("FAIL rstmid_hold got %b exp 0", bus.rsp_valid);
        else n_pass++;
        bus.req_valid = 4'h0;
        rst           = 1'b0;
        @(negedge clk); #1;
        n_checks++;
        if (bus.rsp_valid !== 1'b0) $display("FAIL rstmid_after got %b exp 0", bus.rsp_valid);
        else n_pass++;
        @(negedge clk);
        test_op("rstmid_sub", 3, 8'h10, 8'h10, 1'b1, 8'h00, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_op("add",       0, 8'h25, 8'h1A, 1'b0, 8'h3F, 1'b0);
        test_op("sub_borrow", 2, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b1);
        test_op("sub_plain", 2, 8'h07, 8'h05, 1'b1, 8'h02, 1'b0);
        test_op("add_ovf",   1, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        test_round_robin();
        test_backpressure();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
